// File: rtl/mul_issue_if.sv
// mul_issue_if: requester issue and response handshakes
// for the shared multiplier arbiter.
interface mul_issue_if #(
  parameter int NREQ = 2
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [2*NREQ-1:0]  req_op;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_data;

  modport master (
    output req_valid,
    output req_op,
    output req_a,
    output req_b,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_id,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_a,
    input  req_b,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_id,
    output rsp_data
  );
endinterface

// File: rtl/mul_issue_arbiter.sv
// mul_issue_arbiter: round-robin issue of RV32M multiplies
// onto one shared signed 32x32 pipelined multiplier.
module mul_issue_arbiter #(
  parameter int NREQ    = 2,
  parameter int LATENCY = 9
) (
  input  logic        clk,
  input  logic        rst,
  mul_issue_if.slave  bus,
  output logic        mul_en,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_p,
  output logic        idle
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
    logic [1:0]     op;
    logic [31:0]    corr;
  } tag_t;

  tag_t           tags [LATENCY];
  tag_t           last_tag;
  tag_t           new_tag;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] win;
  logic           found;
  logic           accept;
  logic           any_v;
  logic [31:0]    win_a;
  logic [31:0]    win_b;
  logic [1:0]     win_op;
  logic [31:0]    corr;
  logic [31:0]    hi;

  assign last_tag = tags[LATENCY-1];
  assign mul_en   = ~(last_tag.v & ~bus.rsp_ready);

  always_comb begin : arb
    int             idx;
    logic [IDW-1:0] cand;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx  = (int'(last_grant) + k) % NREQ;
      cand = IDW'(idx);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign accept = found & mul_en & ~rst;

  always_comb begin
    bus.req_ready = '0;
    if (accept) begin
      bus.req_ready[win] = 1'b1;
    end
  end

  assign win_a  = bus.req_a[32*int'(win) +: 32];
  assign win_b  = bus.req_b[32*int'(win) +: 32];
  assign win_op = bus.req_op[2*int'(win) +: 2];

  assign mul_a = accept ? win_a : 32'h0;
  assign mul_b = accept ? win_b : 32'h0;

  // Fold unsigned operand weight back into the signed high word.
  always_comb begin
    case (win_op)
      2'b10:   corr = win_b[31] ? win_a : 32'h0;
      2'b11:   corr = (win_a[31] ? win_b : 32'h0)
                    + (win_b[31] ? win_a : 32'h0);
      default: corr = 32'h0;
    endcase
  end

  always_comb begin
    new_tag = '0;
    if (accept) begin
      new_tag.v    = 1'b1;
      new_tag.id   = win;
      new_tag.op   = win_op;
      new_tag.corr = corr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        tags[i] <= '0;
      end
      last_grant <= LAST_ID;
    end else if (mul_en) begin
      tags[0] <= new_tag;
      for (int i = 1; i < LATENCY; i++) begin
        tags[i] <= tags[i-1];
      end
      if (accept) begin
        last_grant <= win;
      end
    end
  end

  always_comb begin
    any_v = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      any_v = any_v | tags[i].v;
    end
  end

  assign idle = ~any_v & ~accept;

  assign hi = mul_p[63:32];

  always_comb begin
    case (last_tag.op)
      2'b00:   bus.rsp_data = mul_p[31:0];
      2'b01:   bus.rsp_data = hi;
      default: bus.rsp_data = hi + last_tag.corr;
    endcase
  end

  assign bus.rsp_valid = last_tag.v;
  assign bus.rsp_id    = last_tag.id;
endmodule

// File: tb/tb_mul_issue_arbiter.sv
// tb_mul_issue_arbiter: directed checks of arbitration,
// op correction, stall and reset with a modelled multiplier.
module tb_mul_issue_arbiter;
  localparam int NREQ = 2;
  localparam int LAT  = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mul_en;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_p;
  logic        idle;
  logic [63:0] pipe [LAT];

  int n_chk  = 0;
  int n_fail = 0;
  int n;
  logic seen;

  logic [1:0]  grant22 [6] = '{2'b01, 2'b10, 2'b01,
                               2'b10, 2'b01, 2'b10};
  logic [31:0] mula22  [6] = '{32'h10, 32'h21, 32'h12,
                               32'h23, 32'h14, 32'h25};
  logic [31:0] data22  [6] = '{32'h10, 32'h42, 32'h36,
                               32'h8C, 32'h64, 32'hDE};

  mul_issue_if #(.NREQ(NREQ)) bus ();

  mul_issue_arbiter #(
    .NREQ    (NREQ),
    .LATENCY (LAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave),
    .mul_en (mul_en),
    .mul_a  (mul_a),
    .mul_b  (mul_b),
    .mul_p  (mul_p),
    .idle   (idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mul_en) begin
      pipe[0] <= $signed({{32{mul_a[31]}}, mul_a})
               * $signed({{32{mul_b[31]}}, mul_b});
      for (int i = 1; i < LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign mul_p = pipe[LAT-1];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i,
                         input logic [1:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b);
    bus.req_op[2*i +: 2]  = op;
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
    bus.req_valid = bus.req_valid | (2'b01 << i);
  endtask

  task automatic wait_rsp(output int cnt);
    cnt = 0;
    while (!bus.rsp_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    bus.req_valid = 2'b11;
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_mul_en", 64'(mul_en), 64'd1);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);

    // MULHU -1 * -1
    set_req(0, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
    #1;
    chk("s19_ready", 64'(bus.req_ready), 64'h1);
    chk("s19_mul_a", 64'(mul_a), 64'hFFFFFFFF);
    chk("s19_mul_b", 64'(mul_b), 64'hFFFFFFFF);
    chk("s19_idle_busy", 64'(idle), 64'd0);
    @(negedge clk);
    bus.req_valid = '0;
    wait_rsp(n);
    chk("s19_latency", 64'(n + 1), 64'd9);
    chk("s19_id", 64'(bus.rsp_id), 64'd0);
    chk("s19_data", 64'(bus.rsp_data), 64'hFFFFFFFE);
    @(negedge clk);
    chk("s19_drain", 64'(bus.rsp_valid), 64'd0);
    chk("s19_idle", 64'(idle), 64'd1);

    // MULHSU
    set_req(0, 2'b10, 32'hFFFFFFFF, 32'h80000000);
    #1;
    chk("s21_ready", 64'(bus.req_ready), 64'h1);
    @(negedge clk);
    bus.req_valid = '0;
    wait_rsp(n);
    chk("s21_valid", 64'(bus.rsp_valid), 64'd1);
    chk("s21_id", 64'(bus.rsp_id), 64'd0);
    chk("s21_data", 64'(bus.rsp_data), 64'hFFFFFFFF);
    @(negedge clk);

    // MULH then MUL from requester 1
    set_req(1, 2'b01, 32'hFFFFFFFE, 32'h3);
    #1;
    chk("s20_ready0", 64'(bus.req_ready), 64'h2);
    @(negedge clk);
    set_req(1, 2'b00, 32'hFFFFFFFE, 32'h3);
    #1;
    chk("s20_ready1", 64'(bus.req_ready), 64'h2);
    @(negedge clk);
    bus.req_valid = '0;
    wait_rsp(n);
    chk("s20_valid", 64'(bus.rsp_valid), 64'd1);
    chk("s20_id", 64'(bus.rsp_id), 64'd1);
    chk("s20_mulh", 64'(bus.rsp_data), 64'hFFFFFFFF);
    @(negedge clk);
    chk("s20_valid2", 64'(bus.rsp_valid), 64'd1);
    chk("s20_mul", 64'(bus.rsp_data), 64'hFFFFFFFA);
    @(negedge clk);
    chk("s20_drain", 64'(bus.rsp_valid), 64'd0);

    // both requesters contend for 6 cycles
    for (int k = 0; k < 6; k++) begin
      set_req(0, 2'b00, 32'h10 + k, 32'(k + 1));
      set_req(1, 2'b00, 32'h20 + k, 32'(k + 1));
      #1;
      chk($sformatf("s22_grant%0d", k),
          64'(bus.req_ready), 64'(grant22[k]));
      chk($sformatf("s22_mul_a%0d", k),
          64'(mul_a), 64'(mula22[k]));
      @(negedge clk);
    end
    bus.req_valid = '0;
    wait_rsp(n);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("s22_valid%0d", k),
          64'(bus.rsp_valid), 64'd1);
      chk($sformatf("s22_id%0d", k),
          64'(bus.rsp_id), 64'(k % 2));
      chk($sformatf("s22_data%0d", k),
          64'(bus.rsp_data), 64'(data22[k]));
      @(negedge clk);
    end
    chk("s22_drain", 64'(bus.rsp_valid), 64'd0);

    // backpressure stall
    for (int k = 0; k < 4; k++) begin
      set_req(0, 2'b00, 32'h100 + k, 32'h2);
      @(negedge clk);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    wait_rsp(n);
    for (int s = 0; s < 5; s++) begin
      set_req(0, 2'b00, 32'h999, 32'h5);
      #1;
      chk($sformatf("s23_valid%0d", s),
          64'(bus.rsp_valid), 64'd1);
      chk($sformatf("s23_en%0d", s), 64'(mul_en), 64'd0);
      chk($sformatf("s23_ready%0d", s),
          64'(bus.req_ready), 64'd0);
      chk($sformatf("s23_mul_a%0d", s), 64'(mul_a), 64'd0);
      chk($sformatf("s23_data%0d", s),
          64'(bus.rsp_data), 64'h200);
      @(negedge clk);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("s23_rvalid%0d", k),
          64'(bus.rsp_valid), 64'd1);
      chk($sformatf("s23_rdata%0d", k),
          64'(bus.rsp_data), 64'(32'h200 + 2 * k));
      @(negedge clk);
    end
    chk("s23_drain", 64'(bus.rsp_valid), 64'd0);

    // reset with an operation in flight
    set_req(0, 2'b00, 32'h5, 32'h7);
    #1;
    chk("s24_ready", 64'(bus.req_ready), 64'h1);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("s24_idle", 64'(idle), 64'd1);
    chk("s24_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("s24_mul_en", 64'(mul_en), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("s24_no_rsp", 64'(seen), 64'd0);
    set_req(0, 2'b00, 32'h6, 32'h7);
    set_req(1, 2'b00, 32'h9, 32'h9);
    #1;
    chk("s24_grant_after", 64'(bus.req_ready), 64'h1);
    @(negedge clk);
    bus.req_valid = '0;
    wait_rsp(n);
    chk("s24_latency", 64'(n + 1), 64'd9);
    chk("s24_id", 64'(bus.rsp_id), 64'd0);
    chk("s24_data", 64'(bus.rsp_data), 64'h2A);
    @(negedge clk);
    chk("s24_drain", 64'(bus.rsp_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
